scroll_loader: RTL and testbench
================================

SCROLL_LOADER -- requirements
Module: scroll_loader

Interface
REQ-001 Parameter: MSG_LEN, default 64, message length in columns; legal range 32..64.
REQ-002 Parameter: SCROLL_PERIOD, default 24'd1_000_000, idle CLK cycles between scroll steps; legal range 2..2^24-1.
REQ-003 CLK  input  1  system clock; all state changes on posedge CLK.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 ENABLE  input  1  high = periodic scroll bursts allowed.
REQ-006 DIR  input  1  0 = scroll left (offset +1), 1 = scroll right (offset -1).
REQ-007 REFRESH  input  1  one-cycle request: rewrite all 32 columns without moving the offset.
REQ-008 wr_en  input  1  message-memory write strobe.
REQ-009 wr_addr  input  6  message column address; writes with wr_addr >= MSG_LEN are ignored.
REQ-010 wr_data  input  16  message column bitmap.
REQ-011 column_id  output  5  display column being written (0..31).
REQ-012 in_column  output  16  bitmap for column_id.
REQ-013 LOAD  output  1  write strobe to the display; the display samples on the rising edge.
REQ-014 BUSY  output  1  high while a burst is in progress.
REQ-015 FRAME_DONE  output  1  one-cycle pulse when a burst completes.

Function
REQ-016 Storage: MSG_LEN x 16 register array; a write lands on the posedge where wr_en=1; reads are combinational and return the new data from the next cycle onward.
REQ-017 Offset register: 6 bits, range 0..MSG_LEN-1.
REQ-018 States: IDLE, SETUP, STROBE, HOLD.
REQ-019 Period counter: counts only in IDLE with ENABLE=1; it holds its value when ENABLE=0 and clears to 0 when a burst starts.
REQ-020 Scroll trigger: counter == SCROLL_PERIOD-1 in IDLE with ENABLE=1 -> next state SETUP, column k=0, advance flag=1.
REQ-021 Refresh trigger: REFRESH=1 in IDLE -> SETUP with k=0 and advance flag=0; if the scroll trigger is present in the same cycle, the scroll trigger wins (advance flag=1).
REQ-022 REFRESH asserted outside IDLE is dropped and is not queued.
REQ-023 SETUP: column_id=k, in_column=msg[(offset+k) mod MSG_LEN], LOAD=0 -> STROBE.
REQ-024 STROBE: LOAD=1; column_id and in_column held -> HOLD.
REQ-025 HOLD: LOAD=0; column_id and in_column held; if k<31 then k+1 and go to SETUP, else go to IDLE.
REQ-026 Timing: each column takes exactly 3 cycles, so a burst is 96 cycles; LOAD is high for exactly 1 cycle per column and for 32 cycles per burst.
REQ-027 Data stability: column_id and in_column change only on entry to SETUP, so they are stable for at least 1 cycle before and 1 cycle after each LOAD rising edge.
REQ-028 Data capture: in_column is registered at SETUP entry; a message write during STROBE or HOLD does not alter the held value.
REQ-029 Burst completion: on the HOLD->IDLE transition of column 31, FRAME_DONE=1 for 1 cycle.
REQ-030 Offset update on the same edge, only if the advance flag is set: DIR=0 -> offset+1, wrapping MSG_LEN-1 -> 0; DIR=1 -> offset-1, wrapping 0 -> MSG_LEN-1.
REQ-031 DIR is sampled at burst completion.
REQ-032 BUSY=1 in SETUP, STROBE and HOLD; BUSY=0 in IDLE.
REQ-033 ENABLE falling mid-burst: the burst completes normally and the offset is still advanced.
REQ-034 Index arithmetic: (offset+k) is computed 7 bits wide; MSG_LEN is subtracted once when the sum is >= MSG_LEN.

Reset
REQ-035 RESET=1 forces at once: state IDLE, k=0, offset=0, period counter=0, advance flag=0, column_id=0, in_column=0, LOAD=0, BUSY=0, FRAME_DONE=0.
REQ-036 Message memory is not reset.
REQ-037 RESET mid-burst aborts the burst: LOAD drops the same instant, no FRAME_DONE is produced and the offset does not change.
REQ-038 After RESET falls, the first scroll trigger occurs SCROLL_PERIOD cycles later if ENABLE=1.

Verification
REQ-039 SCROLL_PERIOD=4, msg[i]=i, ENABLE=1, DIR=0 -> first LOAD rises 6 cycles after reset release; 32 LOADs with column_id k carrying in_column=k; FRAME_DONE at cycle 96 of the burst; offset=1; next burst carries in_column=k+1.
REQ-040 offset=63, DIR=0, MSG_LEN=64 -> column 0 carries msg[63], column 1 carries msg[0]; offset becomes 0 after the burst.
REQ-041 offset=0, DIR=1 -> offset becomes 63; REFRESH burst -> offset unchanged, column data identical to the previous burst.
REQ-042 REFRESH and scroll trigger in the same cycle -> one burst only, offset advances; REFRESH pulsed during BUSY -> ignored, no second burst.
REQ-043 RESET at burst cycle 40 -> LOAD=0, BUSY=0 immediately; no FRAME_DONE; offset=0; msg contents intact.
REQ-044 Write msg[offset+5]=16'hBEEF while the burst is at k=2 -> column 5 carries 16'hBEEF; write to the address of the column currently in HOLD -> held in_column unchanged.

Source files
------------

// File: rtl/scroll_loader.sv
// scroll_loader
//   Streams a window of 32 columns from a circular message memory into a
//   column-addressed display, one column every 3 cycles (SETUP/STROBE/HOLD).
//   Bursts start periodically (scroll, offset moves at the end) or on a
//   REFRESH request (rewrite, offset unchanged).
//
// Ports
//   CLK, RESET          clock, asynchronous active-high reset
//   ENABLE              allow periodic scroll bursts
//   DIR                 0 = offset+1, 1 = offset-1 (sampled at burst end)
//   REFRESH             one-cycle rewrite request, honoured only in IDLE
//   wr_en/wr_addr/wr_data  message memory write port
//   column_id/in_column display column address and bitmap (registered)
//   LOAD                display write strobe
//   BUSY                burst in progress
//   FRAME_DONE          high during the final HOLD of a burst
module scroll_loader #(
    parameter int          MSG_LEN       = 64,
    parameter logic [23:0] SCROLL_PERIOD = 24'd1_000_000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic        DIR,
    input  logic        REFRESH,
    input  logic        wr_en,
    input  logic [5:0]  wr_addr,
    input  logic [15:0] wr_data,
    output logic [4:0]  column_id,
    output logic [15:0] in_column,
    output logic        LOAD,
    output logic        BUSY,
    output logic        FRAME_DONE
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

    localparam logic [6:0] LEN7 = 7'(MSG_LEN);
    localparam logic [5:0] LAST = 6'(MSG_LEN - 1);

    logic [15:0] r_mem [MSG_LEN];

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_k;
    logic [4:0]  w_k_nxt;
    logic [23:0] r_cnt;
    logic        r_adv;
    logic [5:0]  r_offset;
    logic [4:0]  r_col;
    logic [15:0] r_data;
    logic        w_trig;
    logic        w_start;
    logic [6:0]  w_sum;
    logic [5:0]  w_idx;

    // Message memory: no reset, writes past the message end are dropped.
    always_ff @(posedge CLK) begin
        if (wr_en && ({1'b0, wr_addr} < LEN7))
            r_mem[wr_addr] <= wr_data;
    end

    // Next state, column counter and strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_start     = 1'b0;
        w_trig      = ENABLE && (r_cnt == SCROLL_PERIOD - 24'd1);
        LOAD        = 1'b0;
        BUSY        = 1'b1;
        FRAME_DONE  = 1'b0;
        case (r_state)
            S_IDLE: begin
                BUSY = 1'b0;
                if (w_trig || REFRESH) begin
                    w_state_nxt = S_SETUP;
                    w_k_nxt     = 5'd0;
                    w_start     = 1'b1;
                end
            end
            S_SETUP:  w_state_nxt = S_STROBE;
            S_STROBE: begin
                LOAD        = 1'b1;
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (r_k != 5'd31) begin
                    w_state_nxt = S_SETUP;
                    w_k_nxt     = r_k + 5'd1;
                end else begin
                    w_state_nxt = S_IDLE;
                    FRAME_DONE  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Circular read index for the column about to enter SETUP.
    always_comb begin
        w_sum = {1'b0, r_offset} + {2'b00, w_k_nxt};
        w_idx = (w_sum >= LEN7) ? 6'(w_sum - LEN7) : w_sum[5:0];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= S_IDLE;
            r_k      <= 5'd0;
            r_cnt    <= 24'd0;
            r_adv    <= 1'b0;
            r_offset <= 6'd0;
            r_col    <= 5'd0;
            r_data   <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;

            // Scroll wins over refresh when both fire together.
            if (w_start) begin
                r_cnt <= 24'd0;
                r_adv <= w_trig;
            end else if (r_state == S_IDLE && ENABLE) begin
                r_cnt <= r_cnt + 24'd1;
            end

            if (FRAME_DONE && r_adv) begin
                if (!DIR)
                    r_offset <= (r_offset == LAST) ? 6'd0 : r_offset + 6'd1;
                else
                    r_offset <= (r_offset == 6'd0) ? LAST : r_offset - 6'd1;
            end

            // Column data is captured only on SETUP entry so later memory
            // writes cannot disturb the value the display is sampling.
            if (w_state_nxt == S_SETUP) begin
                r_col  <= w_k_nxt;
                r_data <= r_mem[w_idx];
            end
        end
    end

    assign column_id = r_col;
    assign in_column = r_data;

endmodule

// File: tb/tb_scroll_loader.sv
module tb_scroll_loader;

    localparam int L = 64;

    logic        CLK;
    logic        RESET;
    logic        ENABLE;
    logic        DIR;
    logic        REFRESH;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic [4:0]  column_id;
    logic [15:0] in_column;
    logic        LOAD;
    logic        BUSY;
    logic        FRAME_DONE;

    int          n_assert = 0;
    int          n_fail   = 0;

    // Reference model: message contents and current window offset.
    logic [15:0] mem_m [L];
    int          off_m = 0;

    scroll_loader #(.MSG_LEN(L), .SCROLL_PERIOD(24'd4)) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .DIR(DIR), .REFRESH(REFRESH),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .column_id(column_id), .in_column(in_column),
        .LOAD(LOAD), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = 6'(a); wr_data = d;
        mem_m[a] = d;
        @(negedge CLK);
        wr_en = 1'b0;
    endtask

    // Follows one burst cycle by cycle from its first SETUP cycle.
    // act: 0 none, 1 memory write, 2 flip DIR, 3 drop ENABLE,
    //      4 pulse REFRESH, 5 assert RESET (abort)
    task automatic burst(input int act_cyc, input int act, input int a,
                         input logic [15:0] d, input bit adv);
        int          waited;
        logic [15:0] exp_d;
        waited = 0;
        while (BUSY !== 1'b1 && waited < 300) begin
            @(negedge CLK);
            waited++;
        end
        chk("burst_start", BUSY, 1);
        if (BUSY !== 1'b1) return;
        exp_d = mem_m[off_m % L];
        for (int c = 0; c < 96; c++) begin
            chk("load",       LOAD,       (c % 3 == 1));
            chk("busy",       BUSY,       1);
            chk("frame_done", FRAME_DONE, (c == 95));
            chk("column_id",  column_id,  c / 3);
            chk("in_column",  in_column,  exp_d);
            wr_en   = 1'b0;
            REFRESH = 1'b0;
            // Next column is captured at the coming edge, before any write
            // issued in this cycle lands.
            if ((c + 1) % 3 == 0 && c < 95)
                exp_d = mem_m[(off_m + (c + 1) / 3) % L];
            if (c == act_cyc) begin
                case (act)
                    1: begin wr_en = 1'b1; wr_addr = 6'(a); wr_data = d; mem_m[a] = d; end
                    2: DIR = ~DIR;
                    3: ENABLE = 1'b0;
                    4: REFRESH = 1'b1;
                    5: begin
                        RESET = 1'b1;
                        #1;
                        chk("rst_load",  LOAD,       0);
                        chk("rst_busy",  BUSY,       0);
                        chk("rst_fdone", FRAME_DONE, 0);
                        chk("rst_col",   column_id,  0);
                        chk("rst_data",  in_column,  0);
                        off_m = 0;
                        return;
                    end
                    default: ;
                endcase
            end
            @(negedge CLK);
        end
        wr_en   = 1'b0;
        REFRESH = 1'b0;
        chk("end_busy",  BUSY,       0);
        chk("end_load",  LOAD,       0);
        chk("end_fdone", FRAME_DONE, 0);
        if (adv) begin
            if (!DIR) off_m = (off_m + 1) % L;
            else      off_m = (off_m == 0) ? L - 1 : off_m - 1;
        end
    endtask

    task automatic refresh_burst(input int act_cyc, input int act, input int a,
                                 input logic [15:0] d);
        REFRESH = 1'b1;
        @(negedge CLK);
        REFRESH = 1'b0;
        burst(act_cyc, act, a, d, 1'b0);
    endtask

    task automatic expect_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            chk(tag, BUSY, 0);
        end
    endtask

    initial begin
        RESET = 1'b0; ENABLE = 1'b0; DIR = 1'b0; REFRESH = 1'b0;
        wr_en = 1'b0; wr_addr = 6'd0; wr_data = 16'd0;
        #2 RESET = 1'b1;
        @(negedge CLK);
        chk("reset_col",   column_id,  0);
        chk("reset_data",  in_column,  0);
        chk("reset_load",  LOAD,       0);
        chk("reset_busy",  BUSY,       0);
        chk("reset_fdone", FRAME_DONE, 0);

        // msg[i] = i, loaded while reset is held
        for (int i = 0; i < L; i++) wr(i, 16'(i));

        // First burst: SETUP in cycle 5, LOAD in cycle 6 after release.
        ENABLE = 1'b1;
        RESET  = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge CLK);
            chk("first_trigger", BUSY, (i == 4));
            chk("first_load",    LOAD, 0);
        end
        burst(-1, 0, 0, 16'd0, 1'b1);   // columns carry k, offset -> 1
        burst(-1, 0, 0, 16'd0, 1'b1);   // columns carry k+1, offset -> 2

        // Random message with scrolling paused.
        ENABLE = 1'b0;
        DIR    = 1'b1;
        for (int i = 0; i < L; i++) wr(i, 16'($urandom));
        chk("paused_idle", BUSY, 0);

        // Two refreshes: identical data, offset stays at 2.
        refresh_burst(-1, 0, 0, 16'd0);
        refresh_burst(-1, 0, 0, 16'd0);

        // Scroll right 2 -> 1 -> 0 -> 63.
        ENABLE = 1'b1;
        burst(-1, 0, 0, 16'd0, 1'b1);
        burst(-1, 0, 0, 16'd0, 1'b1);
        burst(-1, 0, 0, 16'd0, 1'b1);

        // Offset 63 scrolling left: column 0 = msg[63], column 1 = msg[0].
        DIR = 1'b0;
        burst(-1, 0, 0, 16'd0, 1'b1);
        // DIR changed mid-burst takes effect at completion: 0 -> 63.
        burst(50, 2, 0, 16'd0, 1'b1);
        // ENABLE dropped mid-burst: burst completes, offset 63 -> 0.
        DIR = 1'b0;
        burst(30, 3, 0, 16'd0, 1'b1);
        expect_idle("enable_off_idle", 8);

        // Write msg[offset+5] while at column 2.
        refresh_burst(7, 1, (off_m + 5) % L, 16'hBEEF);
        // Write the column in STROBE: its held value must not change.
        refresh_burst(31, 1, (off_m + 10) % L, 16'h1234);
        // REFRESH during a burst is dropped.
        refresh_burst(20, 4, 0, 16'd0);
        expect_idle("refresh_busy_dropped", 10);
        // Random write at a random point of a burst.
        refresh_burst(int'($urandom_range(0, 94)), 1, int'($urandom_range(0, L - 1)),
                      16'($urandom));
        refresh_burst(-1, 0, 0, 16'd0);

        // REFRESH coincident with the scroll trigger: one advancing burst.
        ENABLE = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        REFRESH = 1'b1;
        @(negedge CLK);
        REFRESH = 1'b0;
        ENABLE  = 1'b0;
        chk("coincident_start", BUSY, 1);
        burst(-1, 0, 0, 16'd0, 1'b1);
        expect_idle("coincident_single", 10);
        refresh_burst(-1, 0, 0, 16'd0);

        // Reset at burst cycle 40 aborts it; memory survives.
        ENABLE = 1'b1;
        burst(40, 5, 0, 16'd0, 1'b1);
        @(negedge CLK);
        chk("held_reset_busy", BUSY, 0);
        RESET = 1'b0;
        burst(-1, 0, 0, 16'd0, 1'b1);
        burst(-1, 0, 0, 16'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
